// File: rtl/imm_pkg.sv
// Shared encoding constants for the immediate encoder and the ID-stage sign extender.
package imm_pkg;

  localparam logic [1:0] IMM_U12 = 2'b00;  // 12-bit unsigned
  localparam logic [1:0] IMM_U8  = 2'b01;  // 8-bit unsigned
  localparam logic [1:0] IMM_S12 = 2'b10;  // 12-bit two's complement
  localparam logic [1:0] IMM_ERR = 2'b11;  // not representable

  localparam int NUM_W = 12;

  // One buffered encoder result.
  typedef struct packed {
    logic             err;
    logic [1:0]       src;
    logic [NUM_W-1:0] num;
  } enc_word_t;

endpackage

// File: rtl/imm_classify.sv
// Combinational selection of the narrowest encoding that round-trips through the extender.
module imm_classify
  import imm_pkg::*;
#(
  parameter int VAL_W = 21
) (
  input  logic [VAL_W-1:0] i_val,
  output logic [1:0]       o_src,
  output logic [NUM_W-1:0] o_num,
  output logic             o_err
);

  // Priority: 8-bit unsigned, then 12-bit unsigned, then 12-bit negative, else error.
  always_comb begin
    o_src = IMM_ERR;
    o_num = '0;
    o_err = 1'b1;
    if (i_val[VAL_W-1:8] == '0) begin
      o_src = IMM_U8;
      o_num = {4'b0000, i_val[7:0]};
      o_err = 1'b0;
    end else if (i_val[VAL_W-1:12] == '0) begin
      o_src = IMM_U12;
      o_num = i_val[11:0];
      o_err = 1'b0;
    end else if (&i_val[VAL_W-1:11]) begin
      o_src = IMM_S12;
      o_num = i_val[11:0];
      o_err = 1'b0;
    end
  end

endmodule

// File: rtl/sign_extend.sv
// ID-stage extender: rebuilds the full-width immediate from the encoded field.
module sign_extend
  import imm_pkg::*;
#(
  parameter int VAL_W = 21
) (
  input  logic [NUM_W-1:0] i_num,
  input  logic [1:0]       i_src,
  output logic [VAL_W-1:0] o_val
);

  // Zero-extend the unsigned forms, replicate bit 11 for the signed form.
  always_comb begin
    o_val = '0;
    case (i_src)
      IMM_U8:  o_val = {{(VAL_W-8){1'b0}}, i_num[7:0]};
      IMM_U12: o_val = {{(VAL_W-NUM_W){1'b0}}, i_num};
      IMM_S12: o_val = {{(VAL_W-NUM_W){i_num[NUM_W-1]}}, i_num};
      default: o_val = '0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: classifies each value, queues results in a 2-entry elastic buffer
// and counts unrepresentable inputs.
// Handshake: a word moves across an interface only on a cycle where its valid and ready
// are both high; valid never depends on ready, and in_ready may depend on out_ready
// so that a full buffer can accept while it drains.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int VAL_W = 21,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] val_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      num_out,
  output logic [1:0]       imm_src,
  output logic             enc_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [1:0]       r_cnt;
  enc_word_t        r_e0;      // head entry, drives the outputs; zero when empty
  enc_word_t        r_e1;
  logic [CNT_W-1:0] r_err_cnt;

  enc_word_t        w_new;
  enc_word_t        w_e0_nxt;
  enc_word_t        w_e1_nxt;
  logic [1:0]       w_cnt_nxt;
  logic             w_push;
  logic             w_pop;

  imm_classify #(.VAL_W(VAL_W)) u_classify (
    .i_val (val_in),
    .o_src (w_new.src),
    .o_num (w_new.num),
    .o_err (w_new.err)
  );

  assign w_pop     = (r_cnt != 2'd0) && out_ready;
  // Held low through reset; a full buffer accepts only when it also drains.
  assign in_ready  = rst_n && ((r_cnt != 2'd2) || w_pop);
  assign w_push    = in_valid && in_ready;

  assign out_valid = (r_cnt != 2'd0);
  assign num_out   = r_e0.num;
  assign imm_src   = r_e0.src;
  assign enc_err   = r_e0.err;
  assign err_cnt   = r_err_cnt;

  // Next buffer contents: entries shift toward the head, vacated slots are zeroed.
  always_comb begin
    w_e0_nxt  = r_e0;
    w_e1_nxt  = r_e1;
    w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    case (r_cnt)
      2'd0: begin
        if (w_push) w_e0_nxt = w_new;
      end
      2'd1: begin
        if (w_pop)       w_e0_nxt = w_push ? w_new : '0;
        else if (w_push) w_e1_nxt = w_new;
      end
      default: begin
        if (w_pop) begin
          w_e0_nxt = r_e1;
          w_e1_nxt = w_push ? w_new : '0;
        end
      end
    endcase
  end

  // Buffer state and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 2'd0;
      r_e0      <= '0;
      r_e1      <= '0;
      r_err_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_e0  <= w_e0_nxt;
      r_e1  <= w_e1_nxt;
      if (w_push && w_new.err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder with an arithmetic reference model and sign_extend round trip.
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int VAL_W = 21;
  localparam int CNT_W = 8;
  localparam int QW    = VAL_W + 15;  // {val, err, src[1:0], num[11:0]}
  localparam int unsigned SAT = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] val_in;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      num_out;
  logic [1:0]       imm_src;
  logic             enc_err;
  logic [CNT_W-1:0] err_cnt;
  logic [VAL_W-1:0] w_sext;

  imm_encoder #(.VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val_in    (val_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num_out   (num_out),
    .imm_src   (imm_src),
    .enc_err   (enc_err),
    .err_cnt   (err_cnt)
  );

  sign_extend #(.VAL_W(VAL_W)) u_sext (
    .i_num (num_out),
    .i_src (imm_src),
    .o_val (w_sext)
  );

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  int unsigned   m_err_cnt;
  int            n_vec;
  int            n_fail;
  int            n_pop;
  bit            acc;

  // Reference encoding from the value ranges, using plain integer arithmetic.
  function automatic logic [QW-1:0] ref_word(input logic [31:0] v);
    logic [31:0] src;
    logic [31:0] num;
    logic        err;
    if (v < 256) begin
      src = 1; num = v; err = 1'b0;
    end else if (v < 4096) begin
      src = 0; num = v; err = 1'b0;
    end else if (v >= (32'd1 << VAL_W) - 2048) begin
      src = 2; num = v % 4096; err = 1'b0;
    end else begin
      src = 3; num = 0; err = 1'b1;
    end
    return {v[VAL_W-1:0], err, src[1:0], num[11:0]};
  endfunction

  function automatic logic [VAL_W-1:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom_range(0, 255);
      1:       v = $urandom_range(256, 4095);
      2:       v = (32'd1 << VAL_W) - $urandom_range(1, 2048);
      default: v = $urandom_range(4096, (32'd1 << VAL_W) - 2049);
    endcase
    return v[VAL_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: check the DUT against the model at the negedge, then advance the model.
  task automatic cycle();
    logic [QW-1:0] f;
    bit exp_rdy;
    bit pop;
    bit push;
    @(negedge clk);
    exp_rdy = (exp_q.size() < 2) || out_ready;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("err_cnt", err_cnt, m_err_cnt);
    if (exp_q.size() != 0) begin
      f = exp_q[0];
      chk("num_out", num_out, f[11:0]);
      chk("imm_src", imm_src, f[13:12]);
      chk("enc_err", enc_err, f[14]);
      if (!f[14]) chk("round_trip", w_sext, f[QW-1:15]);
    end else begin
      chk("idle_num", num_out, 0);
      chk("idle_src", imm_src, 0);
      chk("idle_err", enc_err, 0);
    end
    if (out_valid && out_ready) n_pop++;
    pop  = (exp_q.size() != 0) && out_ready;
    push = in_valid && exp_rdy;
    if (pop) void'(exp_q.pop_front());
    acc = push;
    if (push) begin
      f = ref_word(32'(val_in));
      exp_q.push_back(f);
      if (f[14] && m_err_cnt < SAT) m_err_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one value and hold it until accepted (bounded).
  task automatic send(input logic [VAL_W-1:0] v);
    in_valid = 1'b1;
    val_in   = v;
    acc      = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) break;
    end
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VAL_W-1:0] dir_vals[9];
    n_vec = 0; n_fail = 0; n_pop = 0; m_err_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; val_in = '0; out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_num", num_out, 0);
    chk("rst_src", imm_src, 0);
    chk("rst_err", enc_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Classification and boundary values
    dir_vals = '{21'h000F0, 21'h008F0, 21'h1FFF0F, 21'd255, 21'd256,
                 21'd4095, 21'd4096, 21'h1FF800, 21'h1FF7FF};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(dir_vals[i]);
    repeat (2) cycle();

    // Backpressure: two fill the buffer, the third waits until the consumer drains
    out_ready = 1'b0;
    send(21'h00011);
    send(21'h00922);
    in_valid = 1'b1;
    val_in   = 21'h1FFF33;
    repeat (3) cycle();
    chk("bp_blocked", acc, 0);
    out_ready = 1'b1;
    cycle();
    chk("bp_accept_on_drain", acc, 1);
    in_valid = 1'b0;
    repeat (4) cycle();

    // Throughput: 16 back-to-back words
    n_pop = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      val_in   = rand_val();
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("throughput_pops", n_pop, 16);

    // Counter saturation
    for (int i = 0; i < 300; i++) send(21'($urandom_range(4096, (32'd1 << VAL_W) - 2049)));
    repeat (3) cycle();
    chk("err_cnt_sat", err_cnt, SAT);

    // Reset with two words buffered
    out_ready = 1'b0;
    send(21'h00055);
    send(21'h1FFFFF);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    m_err_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      val_in    = rand_val();
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", out_valid, 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
